ls_nios_mult_pipe: RTL and testbench

Parametrised, pipelined integer multiply / multiply-accumulate unit for the ls_nios CPU datapath and its coprocessor-style custom instructions. It generalises the fixed 32x32, two-register multiply cell in four ways:
- configurable operand width and pipeline depth;
- per-operation sign and high/low word selection;
- an internal accumulator;
- a valid/ready handshake with full-pipeline backpressure and flush.

It sits between the E-stage operand muxes and the writeback mux.

---
 rtl/ls_nios_mult_pkg.sv | 33 +++
 rtl/ls_nios_mult_core.sv | 42 ++++
 rtl/ls_nios_mult_pipe.sv | 155 +++++++++++++++
 tb/tb_ls_nios_mult_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_nios_mult_pkg.sv
// Shared types and decode helpers for the ls_nios pipelined multiply/MAC unit.
package ls_nios_mult_pkg;

  localparam int DATA_W_MIN      = 8;
  localparam int DATA_W_MAX      = 64;
  localparam int PIPE_STAGES_MIN = 2;
  localparam int PIPE_STAGES_MAX = 4;

  typedef enum logic [2:0] {
    OP_MUL     = 3'd0,
    OP_MULH    = 3'd1,
    OP_MULHSU  = 3'd2,
    OP_MULHU   = 3'd3,
    OP_MAC     = 3'd4,
    OP_ACC_CLR = 3'd5,
    OP_RSV6    = 3'd6,
    OP_RSV7    = 3'd7
  } mult_op_e;

  // Returns {sign_a, sign_b}; MUL uses unsigned since its low word is sign-agnostic.
  function automatic logic [1:0] op_signs(input mult_op_e op);
    case (op)
      OP_MULH, OP_MAC: op_signs = 2'b11;
      OP_MULHSU:       op_signs = 2'b10;
      default:         op_signs = 2'b00;
    endcase
  endfunction

  function automatic logic op_hi(input mult_op_e op);
    op_hi = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/ls_nios_mult_core.sv
// (DATA_W+1)x(DATA_W+1) two's-complement multiplier with PIPE_STAGES-2 register stages.
module ls_nios_mult_core #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic [DATA_W:0]       a_i,
  input  logic [DATA_W:0]       b_i,
  output logic [2*DATA_W-1:0]   prod_o
);

  localparam int PW   = 2 * DATA_W;
  localparam int NREG = PIPE_STAGES - 2;

  logic [PW-1:0] a_w, b_w, prod_c;

  // Sign-extending to the kept width makes the low PW bits of a plain
  // multiply equal to the exact signed product modulo 2^PW.
  assign a_w    = {{(PW-DATA_W-1){a_i[DATA_W]}}, a_i};
  assign b_w    = {{(PW-DATA_W-1){b_i[DATA_W]}}, b_i};
  assign prod_c = a_w * b_w;

  if (NREG == 0) begin : g_comb
    assign prod_o = prod_c;
  end else begin : g_regs
    logic [PW-1:0] pipe_q [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < NREG; i++) pipe_q[i] <= '0;
      end else if (en_i) begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < NREG; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign prod_o = pipe_q[NREG-1];
  end

endmodule

// File: rtl/ls_nios_mult_pipe.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready handshake, flush
// and an optional final-stage accumulator.
module ls_nios_mult_pipe
  import ls_nios_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_EN      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_full,
  output logic [DATA_W-1:0]   out_word
);

  localparam int PW = 2 * DATA_W;
  localparam int NC = PIPE_STAGES - 1;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("ls_nios_mult_pipe: DATA_W out of range");
  end
  if (PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_pipe
    $error("ls_nios_mult_pipe: PIPE_STAGES out of range");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together (adv); in_ready never looks at in_valid,
  // and flush kills everything in flight plus any same-cycle acceptance.
  logic          adv, accept, last_vld, acc_we;
  logic [1:0]    signs;
  mult_op_e      in_op_e, last_op;
  logic [DATA_W:0] a_q, b_q;
  logic [NC-1:0] vld_q;
  mult_op_e      op_q [NC];
  logic [PW-1:0] prod, full_d, acc_d, acc_q, out_full_q;
  logic [DATA_W-1:0] word_d, out_word_q;
  logic          out_valid_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !flush;
  assign in_op_e  = mult_op_e'(in_op);
  assign signs    = op_signs(in_op_e);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= {signs[1] & in_a[DATA_W-1], in_a};
      b_q <= {signs[0] & in_b[DATA_W-1], in_b};
    end
  end

  // Valid/op chain runs alongside the multiplier registers; bubbles move too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < NC; i++) op_q[i] <= OP_MUL;
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q[0] <= accept;
        for (int i = 1; i < NC; i++) vld_q[i] <= vld_q[i-1];
      end
      if (adv) begin
        op_q[0] <= in_op_e;
        for (int i = 1; i < NC; i++) op_q[i] <= op_q[i-1];
      end
    end
  end

  ls_nios_mult_core #(
    .DATA_W      (DATA_W),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (adv),
    .a_i     (a_q),
    .b_i     (b_q),
    .prod_o  (prod)
  );

  assign last_vld = vld_q[NC-1];
  assign last_op  = op_q[NC-1];

  always_comb begin
    full_d = prod;
    word_d = prod[DATA_W-1:0];
    acc_d  = acc_q;
    acc_we = 1'b0;
    if (op_hi(last_op)) word_d = prod[PW-1:DATA_W];
    case (last_op)
      OP_MAC: begin
        if (ACC_EN != 0) begin
          acc_d  = acc_q + prod;
          acc_we = 1'b1;
          full_d = acc_d;
          word_d = acc_d[DATA_W-1:0];
        end
      end
      OP_ACC_CLR: begin
        full_d = '0;
        word_d = '0;
        acc_d  = '0;
        acc_we = (ACC_EN != 0);
      end
      OP_RSV6, OP_RSV7: begin
        full_d = '0;
        word_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_full_q  <= '0;
      out_word_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= last_vld;
      if (last_vld) begin
        out_full_q <= full_d;
        out_word_q <= word_d;
      end
    end
  end

  if (ACC_EN != 0) begin : g_acc
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) acc_q <= '0;
      else if (!flush && adv && last_vld && acc_we) acc_q <= acc_d;
    end
  end else begin : g_no_acc
    assign acc_q = '0;
  end

  assign out_valid = out_valid_q;
  assign out_full  = out_full_q;
  assign out_word  = out_word_q;

endmodule

// File: tb/tb_ls_nios_mult_pipe.sv
// Directed bench for ls_nios_mult_pipe: vector table plus hand-written
// accumulate, backpressure, flush, latency and reset sequences.
module tb_ls_nios_mult_pipe;
  import ls_nios_mult_pkg::*;

  localparam int DW = 32;
  localparam int PW = 64;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [2:0] in_op = '0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid;
  logic [PW-1:0] out_full;
  logic [DW-1:0] out_word;
  logic r3, v3, r4, v4, rn, vn;
  logic [PW-1:0] f3, f4, fn;
  logic [DW-1:0] w3, w4, wn;

  always #5 clk = ~clk;

  ls_nios_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(2), .ACC_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_full(out_full), .out_word(out_word));

  ls_nios_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(3), .ACC_EN(1)) dut_p3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r3),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(v3), .out_ready(out_ready), .out_full(f3), .out_word(w3));

  ls_nios_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(4), .ACC_EN(1)) dut_p4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(v4), .out_ready(out_ready), .out_full(f4), .out_word(w4));

  ls_nios_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(2), .ACC_EN(0)) dut_na (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rn),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(vn), .out_ready(out_ready), .out_full(fn), .out_word(wn));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_na_q[$];
  bit mon_en = 1'b0;
  bit mon_na_en = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got result 0x%0h expected none", out_full);
      end else begin
        check("sb_full", out_full, exp_q.pop_front());
      end
    end
    if (mon_na_en && vn && out_ready) begin
      if (exp_na_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_na_unexpected: got result 0x%0h expected none", fn);
      end else begin
        check("sb_na_full", fn, exp_na_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Presents one op and returns just after the edge that accepted it.
  task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic r;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1 (op %0d)", op);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [PW-1:0] exp, input logic [PW-1:0] exp_na);
    exp_q.push_back(exp);
    if (mon_na_en) exp_na_q.push_back(exp_na);
    send(op, a, b);
  endtask

  task automatic wait_out(output logic [PW-1:0] f, output logic [DW-1:0] w);
    bit got;
    got = 1'b0;
    f = '0;
    w = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        f = out_full;
        w = out_word;
      end
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_out_timeout: out_valid=0 after 10 cycles, required 1");
    end
    tick();
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] full;
    logic [DW-1:0] word;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    logic [PW-1:0] f, f0, lf2, lf3, lf4;
    logic [DW-1:0] w;
    int lat2, lat3, lat4, nv;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'h00000001};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 32'h00000000};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF};
    vecs[4]  = '{3'd0, 32'h12345678, 32'h00000010, 64'h0000000123456780, 32'h23456780};
    vecs[5]  = '{3'd1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000};
    vecs[6]  = '{3'd2, 32'h80000000, 32'h00000002, 64'hFFFFFFFF00000000, 32'hFFFFFFFF};
    vecs[7]  = '{3'd6, 32'h00000003, 32'h00000004, 64'h0000000000000000, 32'h00000000};
    vecs[8]  = '{3'd3, 32'h80000000, 32'h00000002, 64'h0000000100000000, 32'h00000001};
    vecs[9]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 64'h00000002FFFFFFFA, 32'hFFFFFFFA};
    vecs[10] = '{3'd5, 32'h00000005, 32'h00000005, 64'h0000000000000000, 32'h00000000};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_full", out_full, 64'd0);
    check("reset_out_word", 64'(out_word), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Latency sweep across PIPE_STAGES 2/3/4
    lat2 = 0; lat3 = 0; lat4 = 0;
    lf2 = '0; lf3 = '0; lf4 = '0;
    send(OP_MUL, 32'd7, 32'd9);
    idle();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid && lat2 == 0) begin lat2 = c; lf2 = out_full; end
      if (v3 && lat3 == 0) begin lat3 = c; lf3 = f3; end
      if (v4 && lat4 == 0) begin lat4 = c; lf4 = f4; end
    end
    tick();
    check("lat_p2", 64'(lat2), 64'd2);
    check("lat_p3", 64'(lat3), 64'd3);
    check("lat_p4", 64'(lat4), 64'd4);
    check("lat_p2_full", lf2, 64'd63);
    check("lat_p3_full", lf3, 64'd63);
    check("lat_p4_full", lf4, 64'd63);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      idle();
      wait_out(f, w);
      check($sformatf("vec%0d_full", i), f, vecs[i].full);
      check($sformatf("vec%0d_word", i), 64'(w), 64'(vecs[i].word));
    end

    // Back-to-back accumulate, with and without the accumulator
    mon_en = 1'b1;
    mon_na_en = 1'b1;
    issue(OP_ACC_CLR, 32'd0, 32'd0, 64'd0, 64'd0);
    issue(OP_MAC, 32'd3, 32'd4, 64'd12, 64'd12);
    issue(OP_MAC, 32'd5, 32'd6, 64'd42, 64'd30);
    issue(OP_MAC, 32'hFFFFFFFE, 32'd7, 64'd28, 64'hFFFFFFFFFFFFFFF2);
    idle();
    repeat (4) tick();
    check("acc_sb_drained", 64'(exp_q.size()), 64'd0);
    check("acc_na_sb_drained", 64'(exp_na_q.size()), 64'd0);
    mon_na_en = 1'b0;

    // Backpressure: 4 ops issued while the consumer stalls
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(OP_MUL, DW'(i + 1), 32'h100, 64'((i + 1) * 256), 64'd0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        f0 = out_full;
        repeat (2) @(negedge clk);
        check("bp_stall_stable", out_full, f0);
        check("bp_stall_value", out_full, 64'h100);
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    check("bp_sb_drained", 64'(exp_q.size()), 64'd0);

    // Load acc=42, then flush a MAC one cycle after acceptance
    issue(OP_ACC_CLR, 32'd0, 32'd0, 64'd0, 64'd0);
    issue(OP_MAC, 32'd6, 32'd7, 64'd42, 64'd0);
    idle();
    repeat (3) tick();
    send(OP_MAC, 32'd1, 32'd1);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    tick();
    check("flush_no_valid", 64'(nv), 64'd0);
    issue(3'd7, 32'd5, 32'd5, 64'd0, 64'd0);
    issue(OP_MAC, 32'd0, 32'd0, 64'd42, 64'd0);
    idle();
    repeat (4) tick();
    check("flush_sb_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    send(OP_MAC, 32'd3, 32'd3);
    send(OP_MAC, 32'd1, 32'd1);
    idle();
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_full", out_full, 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    send(OP_MAC, 32'd2, 32'd2);
    idle();
    wait_out(f, w);
    check("rst_mac_full", f, 64'd4);
    check("rst_mac_word", 64'(w), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
